// File: rtl/sync_memory_pkg.sv
// Shared definitions for the clocked scratch memory: sweep FSM state encoding.
package sync_memory_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage : sync_memory_pkg

// File: rtl/sync_memory_read_port.sv
// One registered read port: write-first bypass and forced clear value while sweeping.
module sync_memory_read_port #(
   parameter int unsigned            ADDR_WIDTH  = 8,
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sweeping,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_address,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] read_data
);

   // write_en is the effective write, so a write dropped by clear is never bypassed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_data <= CLEAR_VALUE;
      end else if (sweeping) begin
         read_data <= CLEAR_VALUE;
      end else if (write_en && (read_address == write_address)) begin
         read_data <= write_data;
      end else begin
         read_data <= mem_data;
      end
   end

endmodule : sync_memory_read_port

// File: rtl/sync_memory.sv
// Clocked scratch memory: one write port, READ_PORTS registered read ports,
// and a one-cell-per-cycle clear sweep after reset or on request.
module sync_memory
   import sync_memory_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH  = 8,
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter int unsigned            READ_PORTS  = 2,
   parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             clear,
   input  logic                             write_enable,
   input  logic [ADDR_WIDTH-1:0]            write_address,
   input  logic [DATA_WIDTH-1:0]            write_data,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
   output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
   output logic                             busy,
   output logic                             write_dropped
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   sweep_ptr_q, sweep_ptr_d;
   logic                    busy_d;
   logic                    dropped_d;
   logic                    write_en;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Sweep FSM state, pointer and registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_CLEAR;
         sweep_ptr_q   <= '0;
         busy          <= 1'b1;
         write_dropped <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweep_ptr_q   <= sweep_ptr_d;
         busy          <= busy_d;
         write_dropped <= dropped_d;
      end
   end

   // Next state, array write selection and dropped-write detection
   always_comb begin
      state_d     = state_q;
      sweep_ptr_d = sweep_ptr_q;
      dropped_d   = 1'b0;
      write_en    = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = write_address;
      mem_wdata   = write_data;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = sweep_ptr_q;
            mem_wdata = CLEAR_VALUE;
            dropped_d = write_enable;
            if (clear) begin
               sweep_ptr_d = '0;
            end else if (sweep_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
               sweep_ptr_d = '0;
               state_d     = ST_READY;
            end else begin
               sweep_ptr_d = sweep_ptr_q + ADDR_WIDTH'(1);
            end
         end
         ST_READY: begin
            // clear takes priority over a same-cycle write
            if (clear) begin
               state_d     = ST_CLEAR;
               sweep_ptr_d = '0;
               dropped_d   = write_enable;
            end else if (write_enable) begin
               write_en = 1'b1;
               mem_we   = 1'b1;
            end
         end
         default: begin
            state_d     = ST_CLEAR;
            sweep_ptr_d = '0;
         end
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   // Storage array is never reset directly; the sweep clears it
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_port
      sync_memory_read_port #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .DATA_WIDTH  (DATA_WIDTH),
         .CLEAR_VALUE (CLEAR_VALUE)
      ) u_port (
         .clk           (clk),
         .reset_n       (reset_n),
         .sweeping      (busy),
         .write_en      (write_en),
         .write_address (write_address),
         .write_data    (write_data),
         .read_address  (read_address[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .mem_data      (mem[read_address[p*ADDR_WIDTH +: ADDR_WIDTH]]),
         .read_data     (read_data[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule : sync_memory

// File: tb/tb_sync_memory.sv
// Bench for sync_memory: two configurations (8/8/2 and 4/16/4) against a shared
// array-based reference model, plus directed literal checks.
module tb_sync_memory;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Stimulus per instance (k=0: 8/8/2, k=1: 4/16/4)
   logic        we_s  [2];
   logic        clr_s [2];
   logic [7:0]  wa_s  [2];
   logic [15:0] wd_s  [2];
   logic [7:0]  ra_s  [2][4];

   logic [15:0] a_rd;
   logic [63:0] b_rd;
   logic        a_busy, b_busy, a_drop, b_drop;

   sync_memory u_a (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clr_s[0]),
      .write_enable  (we_s[0]),
      .write_address (wa_s[0]),
      .write_data    (wd_s[0][7:0]),
      .read_address  ({ra_s[0][1], ra_s[0][0]}),
      .read_data     (a_rd),
      .busy          (a_busy),
      .write_dropped (a_drop)
   );

   sync_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_PORTS(4)) u_b (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clr_s[1]),
      .write_enable  (we_s[1]),
      .write_address (wa_s[1][3:0]),
      .write_data    (wd_s[1]),
      .read_address  ({ra_s[1][3][3:0], ra_s[1][2][3:0], ra_s[1][1][3:0], ra_s[1][0][3:0]}),
      .read_data     (b_rd),
      .busy          (b_busy),
      .write_dropped (b_drop)
   );

   function automatic int np(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic int depth(input int k);
      return (k == 0) ? 256 : 16;
   endfunction

   function automatic logic [15:0] act_rd(input int k, input int p);
      return (k == 0) ? {8'h00, a_rd[p*8 +: 8]} : b_rd[p*16 +: 16];
   endfunction

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: array contents plus number of sweep cycles still to run
   logic [15:0] m_mem [2][256];
   int          left  [2];
   logic        e_busy[2];
   logic        e_drop[2];
   logic [15:0] e_rd  [2][4];

   task automatic model_reset(input int k);
      left[k]   = depth(k);
      e_busy[k] = 1'b1;
      e_drop[k] = 1'b0;
      for (int p = 0; p < 4; p++) e_rd[k][p] = '0;
      // the sweep zeroes everything before any read can see the array again
      for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
   endtask

   task automatic model_step(input int k);
      bit sweeping, eff_we;
      sweeping  = (left[k] > 0);
      eff_we    = !sweeping && we_s[k] && !clr_s[k];
      e_drop[k] = we_s[k] && (sweeping || clr_s[k]);
      for (int p = 0; p < np(k); p++) begin
         if (sweeping)                          e_rd[k][p] = '0;
         else if (eff_we && ra_s[k][p] == wa_s[k]) e_rd[k][p] = wd_s[k];
         else                                   e_rd[k][p] = m_mem[k][ra_s[k][p]];
      end
      if (eff_we) m_mem[k][wa_s[k]] = wd_s[k];
      if (clr_s[k]) begin
         left[k] = depth(k);
         for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
      end else if (sweeping) begin
         left[k] = left[k] - 1;
      end
      e_busy[k] = (left[k] > 0);
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_busy", k), (k == 0) ? a_busy : b_busy, e_busy[k]);
            chk($sformatf("u%0d_drop", k), (k == 0) ? a_drop : b_drop, e_drop[k]);
            for (int p = 0; p < np(k); p++)
               chk($sformatf("u%0d_rd%0d", k, p), act_rd(k, p), e_rd[k][p]);
         end
      end
   end

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         we_s[k] = 1'b0; clr_s[k] = 1'b0; wa_s[k] = '0; wd_s[k] = '0;
         for (int p = 0; p < 4; p++) ra_s[k][p] = '0;
      end
   endtask

   task automatic rand_reads();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 4; p++) ra_s[k][p] = 8'($urandom_range(0, depth(k) - 1));
   endtask

   // Count busy samples for both instances until both sweeps finish (bounded)
   task automatic measure(input string tag, input bit both);
      int n, nb;
      n = 0; nb = 0;
      for (int i = 0; i < 2000 && (a_busy || b_busy); i++) begin
         if (a_busy) n++;
         if (b_busy) nb++;
         rand_reads();
         @(negedge clk);
      end
      chk({tag, "_busy_cycles_u0"}, n, 256);
      if (both) chk({tag, "_busy_cycles_u1"}, nb, 16);
   endtask

   initial begin
      idle();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_busy", a_busy, 1);
      chk("reset_rd",   a_rd, 0);
      chk("reset_drop", a_drop, 0);

      // 1: sweep after reset release
      reset_n = 1'b1;
      measure("t1", 1'b1);

      // 2: write then read one cycle later
      we_s[0] = 1'b1; wa_s[0] = 8'h10; wd_s[0] = 16'h003C;
      @(negedge clk);
      idle(); ra_s[0][0] = 8'h10;
      @(negedge clk);
      chk("t2_rd0", a_rd[7:0], 8'h3C);

      // 3: same-cycle bypass on port 0, plain read on port 1
      we_s[0] = 1'b1; wa_s[0] = 8'h21; wd_s[0] = 16'h0011;
      @(negedge clk);
      wa_s[0] = 8'h20; wd_s[0] = 16'h00A5; ra_s[0][0] = 8'h20; ra_s[0][1] = 8'h21;
      @(negedge clk);
      chk("t3_rd0_bypass", a_rd[7:0], 8'hA5);
      chk("t3_rd1",        a_rd[15:8], 8'h11);
      idle();

      // 4: clear beats a same-cycle write; swept cell reads zero
      we_s[0] = 1'b1; wa_s[0] = 8'h05; wd_s[0] = 16'h0077;
      @(negedge clk);
      clr_s[0] = 1'b1; wd_s[0] = 16'h0099;
      @(negedge clk);
      chk("t4_drop", a_drop, 1);
      chk("t4_busy", a_busy, 1);
      idle();
      measure("t4", 1'b0);
      idle(); ra_s[0][0] = 8'h05;
      @(negedge clk);
      chk("t4_rd_cleared", a_rd[7:0], 8'h00);

      // 6: four parallel reads of distinct words on the wide instance
      for (int i = 0; i < 4; i++) begin
         idle();
         we_s[1] = 1'b1; wa_s[1] = 8'(i * 3 + 1); wd_s[1] = 16'hBEE0 + 16'(i);
         @(negedge clk);
      end
      idle();
      for (int p = 0; p < 4; p++) ra_s[1][p] = 8'((3 - p) * 3 + 1);
      @(negedge clk);
      for (int p = 0; p < 4; p++)
         chk($sformatf("t6_rd%0d", p), b_rd[p*16 +: 16], 16'hBEE0 + 16'(3 - p));

      // Random traffic with bypass-biased reads and rare clears
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 2; k++) begin
            we_s[k]  = 1'($urandom_range(0, 1));
            clr_s[k] = ($urandom_range(0, 99) == 0);
            wa_s[k]  = 8'($urandom_range(0, depth(k) - 1));
            wd_s[k]  = (k == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            for (int p = 0; p < 4; p++)
               ra_s[k][p] = ($urandom_range(0, 3) == 0) ? wa_s[k]
                                                        : 8'($urandom_range(0, depth(k) - 1));
         end
         @(negedge clk);
      end
      idle();
      for (int i = 0; i < 600 && (a_busy || b_busy); i++) @(negedge clk);
      chk("rand_settle_busy", {30'd0, a_busy, b_busy}, 0);

      // 5: reset pulse mid-sweep at pointer 0x80, with a dropped write pending
      clr_s[0] = 1'b1;
      @(negedge clk);
      idle();
      we_s[0] = 1'b1;
      repeat (128) @(negedge clk);
      chk("t5_drop_before", a_drop, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_reset_busy", a_busy, 1);
      chk("t5_reset_drop", a_drop, 0);
      chk("t5_reset_rd",   a_rd, 0);
      idle();
      @(negedge clk);
      reset_n = 1'b1;
      measure("t5", 1'b1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_sync_memory
